ecc_mm_final_sub: RTL and testbench

- Output reduction stage directly downstream of the ECC Montgomery multiplier.
- Takes the multiplier result p (range [0, 2n)) and the modulus n, and produces p mod n by one conditional subtraction.
- The subtraction runs word-serially, RADIX bits per cycle with a registered borrow, so the adder width matches the multiplier's PE datapath.
- The ECC arithmetic sequencer drives start_i on the multiplier's ready_o and consumes res_o.

---
 rtl/ecc_mm_final_sub.sv | 110 +++++++++++
 tb/tb_ecc_mm_final_sub.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ecc_mm_final_sub.sv
// Final conditional subtraction after the ECC Montgomery multiplier: res = (p >= n) ? p - n : p.
// The subtraction runs word-serially, RADIX bits per cycle, with a registered borrow.
module ecc_mm_final_sub #(
    parameter int REG_SIZE = 384,
    parameter int RADIX    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [REG_SIZE-1:0] p_i,
    input  logic [REG_SIZE-1:0] n_i,
    output logic [REG_SIZE-1:0] res_o,
    output logic                busy_o,
    output logic                ready_o
);

    localparam int WORDS = REG_SIZE / RADIX;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        SEL
    } state_e;

    state_e              state_q, state_d;
    logic [REG_SIZE-1:0] p_q, p_d;
    logic [REG_SIZE-1:0] n_q, n_d;
    logic [REG_SIZE-1:0] d_q, d_d;
    logic [REG_SIZE-1:0] res_q, res_d;
    logic                borrow_q, borrow_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                ready_q, ready_d;

    logic [RADIX-1:0]    p_word;
    logic [RADIX-1:0]    n_word;
    logic [RADIX:0]      diff;

    assign p_word = p_q[int'(wcnt_q)*RADIX +: RADIX];
    assign n_word = n_q[int'(wcnt_q)*RADIX +: RADIX];
    // The top bit of the (RADIX+1)-bit difference is the outgoing borrow.
    assign diff   = {1'b0, p_word} - {1'b0, n_word} - {{RADIX{1'b0}}, borrow_q};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        p_d      = p_q;
        n_d      = n_q;
        d_d      = d_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        wcnt_d   = wcnt_q;
        ready_d  = 1'b0;

        case (state_q)
            SUB: begin
                d_d      = {diff[RADIX-1:0], d_q[REG_SIZE-1:RADIX]};
                borrow_d = diff[RADIX];
                wcnt_d   = wcnt_q + CNT_W'(1);
                if (wcnt_q == CNT_W'(WORDS - 1)) begin
                    state_d = SEL;
                end
            end
            SEL: begin
                res_d   = borrow_q ? p_q : d_q;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A start in any state (re)captures operands; in SEL the finishing result is still delivered.
        if (start_i) begin
            p_d      = p_i;
            n_d      = n_i;
            borrow_d = 1'b0;
            wcnt_d   = '0;
            state_d  = SUB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: operand and shift registers are cleared too, so nothing stale survives an abort.
            state_q  <= IDLE;
            p_q      <= '0;
            n_q      <= '0;
            d_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            wcnt_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q  <= state_d;
            p_q      <= p_d;
            n_q      <= n_d;
            d_q      <= d_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            wcnt_q   <= wcnt_d;
            ready_q  <= ready_d;
        end
    end

    assign res_o   = res_q;
    assign ready_o = ready_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_ecc_mm_final_sub.sv
// Directed bench for ecc_mm_final_sub: latency, borrow chains, restart, abort and back-to-back operation.
// Observation index k means "sampled on the falling edge after rising edge k", edge 0 being the start edge.
module tb_ecc_mm_final_sub;

    localparam int REG_SIZE = 384;
    localparam int RADIX    = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                start_i;
    logic [REG_SIZE-1:0] p_i;
    logic [REG_SIZE-1:0] n_i;
    logic [REG_SIZE-1:0] res_o;
    logic                busy_o;
    logic                ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [REG_SIZE-1:0] p384;
    logic [REG_SIZE-1:0] nh;
    int                  seen;

    ecc_mm_final_sub #(
        .REG_SIZE(REG_SIZE),
        .RADIX   (RADIX)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start_i(start_i),
        .p_i    (p_i),
        .n_i    (n_i),
        .res_o  (res_o),
        .busy_o (busy_o),
        .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [REG_SIZE-1:0] obs, input logic [REG_SIZE-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; start is sampled by the next rising edge (edge 0), returns at observation 0.
    task automatic pulse_start(input logic [REG_SIZE-1:0] p, input logic [REG_SIZE-1:0] n);
        p_i     = p;
        n_i     = n;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [REG_SIZE-1:0] exp_res, input int first_obs);
        int obs = first_obs;
        while (ready_o !== 1'b1 && obs < 40) begin
            @(negedge clk);
            obs++;
        end
        check({tag, "_latency"}, REG_SIZE'(obs), REG_SIZE'(13));
        check({tag, "_res"}, res_o, exp_res);
        @(negedge clk);
        check({tag, "_ready_width"}, REG_SIZE'(ready_o), '0);
    endtask

    task automatic run_op(input string tag, input logic [REG_SIZE-1:0] p,
                          input logic [REG_SIZE-1:0] n, input logic [REG_SIZE-1:0] exp_res);
        pulse_start(p, n);
        wait_done(tag, exp_res, 0);
    endtask

    initial begin
        reset   = 1'b1;
        start_i = 1'b0;
        p_i     = '0;
        n_i     = '0;
        p384 = {REG_SIZE{1'b1}} - (REG_SIZE'(1) << 128) - (REG_SIZE'(1) << 96) + (REG_SIZE'(1) << 32);
        // 2*p384-1 does not fit in 384 bits, so the 2n-1 case uses a 383-bit modulus.
        nh   = p384 >> 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset_res",   res_o,              '0);
        check("reset_busy",  REG_SIZE'(busy_o),  '0);
        check("reset_ready", REG_SIZE'(ready_o), '0);

        // p < n: borrow survives, p passes through; busy through SEL, ready at edge 13 only.
        pulse_start(REG_SIZE'(5), p384);
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("lt_busy_k%0d", k),  REG_SIZE'(busy_o),  REG_SIZE'(1));
            check($sformatf("lt_ready_k%0d", k), REG_SIZE'(ready_o), '0);
            @(negedge clk);
        end
        check("lt_ready_k13", REG_SIZE'(ready_o), REG_SIZE'(1));
        check("lt_res",       res_o,              REG_SIZE'(5));
        check("lt_busy_k13",  REG_SIZE'(busy_o),  '0);
        @(negedge clk);
        check("lt_ready_k14", REG_SIZE'(ready_o), '0);
        check("lt_res_hold",  res_o,              REG_SIZE'(5));

        run_op("eq",        p384,                          p384,               '0);
        run_op("n_plus_5",  p384 + REG_SIZE'(5),           p384,               REG_SIZE'(5));
        run_op("two_n_m1",  (nh << 1) - REG_SIZE'(1),      nh,                 nh - REG_SIZE'(1));
        run_op("word0",     REG_SIZE'(1) << 32,            REG_SIZE'(32'hFFFF_FFFF), REG_SIZE'(1));
        run_op("zero",      '0,                            p384,               '0);
        run_op("out_range", REG_SIZE'(350),                REG_SIZE'(100),     REG_SIZE'(250));

        // Restart: second start sampled at edge 6 of the first operation; only its result appears.
        pulse_start(p384 + REG_SIZE'(7), p384);
        repeat (5) @(negedge clk);
        pulse_start(p384 + REG_SIZE'(9), p384);
        wait_done("restart", REG_SIZE'(9), 0);

        // Reset at edge 4 of an operation aborts it and clears the result.
        pulse_start(p384 + REG_SIZE'(7), p384);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_res",  res_o,             '0);
        check("abort_busy", REG_SIZE'(busy_o), '0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready_o === 1'b1) seen++;
        end
        check("abort_no_ready", REG_SIZE'(seen), '0);
        run_op("after_abort", REG_SIZE'(3), p384, REG_SIZE'(3));

        // Back-to-back: next start sampled on the same edge that registers the first result.
        pulse_start(p384 + REG_SIZE'(5), p384);
        repeat (12) @(negedge clk);
        check("b2b_sel_busy",  REG_SIZE'(busy_o),  REG_SIZE'(1));
        check("b2b_sel_ready", REG_SIZE'(ready_o), '0);
        pulse_start(p384 + REG_SIZE'(11), p384);
        check("b2b_first_ready", REG_SIZE'(ready_o), REG_SIZE'(1));
        check("b2b_first_res",   res_o,              REG_SIZE'(5));
        check("b2b_second_busy", REG_SIZE'(busy_o),  REG_SIZE'(1));
        @(negedge clk);
        wait_done("b2b_second", REG_SIZE'(11), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
